// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: sequences table initialisation after reset, then queues
// resolved-branch outcomes and drains them into the single pattern-table
// write port, arbitrating against fetch lookups with a starvation guard.
module bp_update_ctrl #(
  parameter int DEPTH     = 4,
  parameter int IDX_W     = 5,
  parameter int STALL_MAX = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_valid_i,
  input  logic [31:0]                ex_addr_i,
  input  logic                       ex_taken_i,
  output logic                       ex_ready_o,
  input  logic                       if_lookup_i,
  output logic                       lookup_stall_o,
  output logic                       tbl_we_o,
  output logic [IDX_W-1:0]           tbl_idx_o,
  output logic                       tbl_taken_o,
  output logic                       tbl_init_o,
  output logic                       init_busy_o,
  output logic [$clog2(DEPTH):0]     pending_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int STALL_W = $clog2(STALL_MAX + 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_init_idx;
  logic [IDX_W-1:0]     r_fifo_idx   [DEPTH];
  logic                 r_fifo_taken [DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic [STALL_W-1:0]   r_stall_cnt;

  logic                 w_run;
  logic                 w_not_full;
  logic                 w_not_empty;
  logic                 w_stall_expired;
  logic                 w_drain;
  logic                 w_push;
  logic [IDX_W-1:0]     w_push_idx;
  logic                 w_unused_addr;

  assign w_run           = (r_state == ST_RUN);
  assign w_not_full      = (r_count < CNT_W'(DEPTH));
  assign w_not_empty     = (r_count != '0);
  assign w_stall_expired = (r_stall_cnt >= STALL_W'(STALL_MAX));
  // An update takes the port when fetch does not need it, or once it has
  // waited long enough that fetch gets overridden.
  assign w_drain         = w_run && w_not_empty && (!if_lookup_i || w_stall_expired);
  // Acceptance uses the pre-pop count: a full FIFO refuses even on a pop cycle.
  assign w_push          = w_run && ex_valid_i && w_not_full;
  // Word-aligned PC: drop the byte offset, keep IDX_W index bits.
  assign w_push_idx      = ex_addr_i[IDX_W+1:2];
  // Only the index bits of the PC matter; the rest is intentionally ignored.
  assign w_unused_addr   = ^{ex_addr_i[31:IDX_W+2], ex_addr_i[1:0]};

  // Mode sequencer: walk every table index once, then switch to update mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_idx <= r_init_idx + IDX_W'(1);
          if (r_init_idx == {IDX_W{1'b1}}) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // FIFO payload storage; contents need no reset because count gates use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_idx[r_tail]   <= w_push_idx;
      r_fifo_taken[r_tail] <= ex_taken_i;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_drain) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation guard: count cycles the head has been deferred by lookups.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_drain || !w_not_empty) begin
      r_stall_cnt <= '0;
    end else if (if_lookup_i && !w_stall_expired) begin
      r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end
  end

  // Port outputs decoded from registered state and the live lookup request.
  always_comb begin
    ex_ready_o     = 1'b0;
    lookup_stall_o = 1'b0;
    tbl_we_o       = 1'b0;
    tbl_idx_o      = '0;
    tbl_taken_o    = 1'b0;
    tbl_init_o     = 1'b0;
    init_busy_o    = 1'b0;
    pending_o      = r_count;
    if (!w_run) begin
      tbl_we_o       = 1'b1;
      tbl_init_o     = 1'b1;
      tbl_idx_o      = r_init_idx;
      init_busy_o    = 1'b1;
      lookup_stall_o = if_lookup_i;
    end else begin
      ex_ready_o     = w_not_full;
      tbl_idx_o      = r_fifo_idx[r_head];
      tbl_taken_o    = r_fifo_taken[r_head];
      tbl_we_o       = w_drain;
      lookup_stall_o = w_drain && if_lookup_i;
    end
  end

endmodule
